// File: rtl/elelock_pkg.sv
// rtl/elelock_pkg.sv - shared types, constants and key encoder for the multi-digit electronic lock
package elelock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_NONE = 4'hF;

  // One-hot 10-key pattern to BCD digit; anything not exactly one-hot maps to KEY_NONE.
  function automatic logic [3:0] keyenc(input logic [9:0] key);
    logic [3:0] digit;
    int         hits;
    digit = KEY_NONE;
    hits  = 0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) begin
        hits  = hits + 1;
        digit = 4'(i);
      end
    end
    if (hits != 1) digit = KEY_NONE;
    return digit;
  endfunction

endpackage

// File: rtl/tenkey_press.sv
// rtl/tenkey_press.sv - keypad input register with one-hot check and release-to-rearm press detect
module tenkey_press
  import elelock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tenkey_i,
  output logic       press_valid_o,
  output logic [3:0] press_digit_o
);

  logic [9:0] key_q;
  logic [9:0] prev_q;
  logic [3:0] digit;

  // Register the keypad once and keep the previous registered value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q  <= '0;
      prev_q <= '0;
    end else begin
      key_q  <= tenkey_i;
      prev_q <= key_q;
    end
  end

  // A press needs a clean one-hot key right after an all-zero sample, so held or
  // multi-key patterns never produce a digit until the keypad is fully released.
  always_comb begin
    digit         = keyenc(key_q);
    press_valid_o = (digit != KEY_NONE) && (prev_q == '0);
    press_digit_o = digit;
  end

endmodule

// File: rtl/multi_digit_elelock.sv
// rtl/multi_digit_elelock.sv - multi-digit code lock with failure counting and timed lockout (option: ENTRY_TIMEOUT_EN)
module multi_digit_elelock
  import elelock_pkg::*;
#(
  parameter int unsigned             DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]     SECRET      = 16'h0007,
  parameter int unsigned             MAX_FAIL    = 3,
  parameter int unsigned             LOCKOUT_CYC = 1024,
  parameter int unsigned             TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       err,
  output logic       lockout,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(LOCKOUT_CYC);
  localparam logic [BW-1:0] BUF_CLEAR = {DIGITS{KEY_NONE}};

  if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 15 ||
      LOCKOUT_CYC < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("multi_digit_elelock: parameter out of range");
  end

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    fail_q, fail_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] lo_q, lo_d;
  logic          press_valid;
  logic [3:0]    press_digit;
  logic          timeout_hit;

  tenkey_press u_press (
    .clk           (clk),
    .reset         (reset),
    .tenkey_i      (tenkey),
    .press_valid_o (press_valid),
    .press_digit_o (press_digit)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          idle_run;

  // Idle timer for a partial entry: any press, close or leaving LOCKED restarts it.
  always_comb begin
    idle_run    = (state_q == LOCKED) && (cnt_q != 4'd0) && !press_valid && !close;
    timeout_hit = idle_run && (idle_q == IW'(TIMEOUT_CYC - 1));
    idle_d      = (idle_run && !timeout_hit) ? idle_q + 1'b1 : '0;
  end

  // Idle timer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOCKED;
      buf_q   <= BUF_CLEAR;
      cnt_q   <= 4'd0;
      fail_q  <= 4'd0;
      lock_q  <= 1'b1;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: digit collection, code check, open hold and lockout countdown.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    lo_d    = lo_q;
    case (state_q)
      LOCKED: begin
        lock_d = 1'b1;
        if (close) begin
          buf_d = BUF_CLEAR;
          cnt_d = 4'd0;
        end else if (press_valid) begin
          buf_d      = buf_q << 4;
          buf_d[3:0] = press_digit;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'(DIGITS - 1)) state_d = CHECK;
        end else if (timeout_hit) begin
          buf_d = BUF_CLEAR;
          cnt_d = 4'd0;
        end
      end
      CHECK: begin
        if (buf_q == SECRET) begin
          state_d = OPEN;
          lock_d  = 1'b0;
          fail_d  = 4'd0;
        end else begin
          fail_d = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
          buf_d  = BUF_CLEAR;
          cnt_d  = 4'd0;
          if (fail_d == 4'(MAX_FAIL)) begin
            state_d = LOCKOUT;
            lo_d    = CW'(LOCKOUT_CYC - 1);
          end else begin
            state_d = LOCKED;
          end
        end
      end
      OPEN: begin
        lock_d = 1'b0;
        if (close) begin
          lock_d  = 1'b1;
          buf_d   = BUF_CLEAR;
          cnt_d   = 4'd0;
          state_d = LOCKED;
        end
      end
      LOCKOUT: begin
        lock_d = 1'b1;
        if (lo_q == '0) begin
          state_d = LOCKED;
          fail_d  = 4'd0;
        end else begin
          lo_d = lo_q - 1'b1;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  assign lock      = lock_q;
  assign err       = (state_q == CHECK) && (buf_q != SECRET);
  assign lockout   = (state_q == LOCKOUT);
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_multi_digit_elelock.sv
// tb/tb_multi_digit_elelock.sv - directed self-checking bench for multi_digit_elelock
module tb_multi_digit_elelock;

  logic       clk;
  logic       reset;
  logic [9:0] tenkey;
  logic       close;
  logic       lock;
  logic       err;
  logic       lockout;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  multi_digit_elelock #(
    .DIGITS      (4),
    .SECRET      (16'h1234),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (16),
    .TIMEOUT_CYC (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tenkey    (tenkey),
    .close     (close),
    .lock      (lock),
    .err       (err),
    .lockout   (lockout),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    tick();
    tenkey = 10'(1 << d);
    tick();
    tenkey = '0;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic do_close();
    tick();
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  int n;

  initial begin
    reset  = 1'b1;
    tenkey = '0;
    close  = 1'b0;
    tick();
    check_eq("rst_lock", lock, 1);
    check_eq("rst_err", err, 0);
    check_eq("rst_lockout", lockout, 0);
    check_eq("rst_digit_cnt", digit_cnt, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    reset = 1'b0;
    tick();

    // correct code: lock still high one cycle after the final press, low the next
    enter4(1, 2, 3, 4);
    tick();
    check_eq("ok_lock_lat1", lock, 1);
    check_eq("ok_cnt_full", digit_cnt, 4);
    check_eq("ok_no_err", err, 0);
    tick();
    check_eq("ok_lock_open", lock, 0);
    check_eq("ok_fail0", fail_cnt, 0);
    do_close();
    check_eq("close_relock", lock, 1);
    check_eq("close_cnt0", digit_cnt, 0);

    // wrong code
    enter4(1, 2, 3, 5);
    tick();
    check_eq("bad_err_pulse", err, 1);
    check_eq("bad_lock", lock, 1);
    tick();
    check_eq("bad_err_end", err, 0);
    check_eq("bad_fail1", fail_cnt, 1);
    check_eq("bad_cnt0", digit_cnt, 0);
    check_eq("bad_lock_after", lock, 1);

    // two more failures -> lockout lasting 16 cycles, presses ignored
    enter4(9, 9, 9, 9);
    tick();
    tick();
    check_eq("bad2_fail2", fail_cnt, 2);
    check_eq("bad2_no_lockout", lockout, 0);
    enter4(0, 0, 0, 0);
    tick();
    check_eq("bad3_err", err, 1);
    tick();
    check_eq("lo_enter", lockout, 1);
    check_eq("lo_fail3", fail_cnt, 3);
    check_eq("lo_lock", lock, 1);
    n = 1;
    while (lockout === 1'b1 && n < 100) begin
      tenkey = (n < 10 && (n % 2) == 1) ? 10'h080 : 10'h000;
      tick();
      if (lockout === 1'b1) n++;
    end
    tenkey = '0;
    check_eq("lo_duration", n, 16);
    check_eq("lo_exit_fail0", fail_cnt, 0);
    check_eq("lo_press_ignored", digit_cnt, 0);
    check_eq("lo_exit_lock", lock, 1);
    enter4(1, 2, 3, 4);
    tick();
    tick();
    check_eq("post_lo_open", lock, 0);
    do_close();
    check_eq("post_lo_close", lock, 1);

    // held key counts once; multi-key pattern gives nothing
    tick();
    tenkey = 10'b0000000010;
    repeat (5) tick();
    tenkey = '0;
    tick();
    tick();
    check_eq("hold_once", digit_cnt, 1);
    tenkey = 10'b0000000011;
    repeat (3) tick();
    tenkey = '0;
    tick();
    tick();
    check_eq("multi_ignored", digit_cnt, 1);
    do_close();
    check_eq("close_partial", digit_cnt, 0);

    // close on the same cycle as a press wins
    press(1);
    press(2);
    tick();
    tenkey = 10'(1 << 3);
    tick();
    tenkey = '0;
    close  = 1'b1;
    tick();
    close  = 1'b0;
    check_eq("close_prio", digit_cnt, 0);
    tick();
    tick();
    check_eq("close_prio_hold", digit_cnt, 0);
    enter4(1, 2, 3, 4);
    tick();
    tick();
    check_eq("after_prio_open", lock, 0);
    tick();
    tenkey = 10'(1 << 5);
    tick();
    tenkey = '0;
    tick();
    tick();
    check_eq("open_press_ignored", lock, 0);
    do_close();
    check_eq("open_close", lock, 1);

    // partial entry: timeout clears it when enabled, otherwise it persists
    press(1);
    tick();
    check_eq("partial_cnt1", digit_cnt, 1);
`ifdef ENTRY_TIMEOUT_EN
    repeat (31) tick();
    check_eq("to_not_yet", digit_cnt, 1);
    tick();
    check_eq("to_cleared", digit_cnt, 0);
    check_eq("to_no_err", err, 0);
    check_eq("to_fail_same", fail_cnt, 0);
`else
    repeat (40) tick();
    check_eq("partial_persist", digit_cnt, 1);
    check_eq("partial_no_err", err, 0);
    do_close();
`endif

    // reset in the middle of a lockout
    enter4(5, 5, 5, 5);
    tick();
    tick();
    enter4(5, 5, 5, 5);
    tick();
    tick();
    enter4(5, 5, 5, 5);
    tick();
    tick();
    tick();
    check_eq("rst2_in_lockout", lockout, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst2_lockout", lockout, 0);
    check_eq("rst2_fail", fail_cnt, 0);
    check_eq("rst2_lock", lock, 1);
    check_eq("rst2_cnt", digit_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    enter4(1, 2, 3, 4);
    tick();
    tick();
    check_eq("rst2_open", lock, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_digit_elelock.md
Name: multi_digit_elelock

Overview:
Parametrised successor to the single-digit electronic lock. It accepts a multi-digit code from a 10-key one-hot keypad and compares it with a BCD secret. It counts failed attempts and enters a timed lockout after too many failures. It sits between the keypad debouncer and the door actuator driver.

Parameters:
DIGITS, 4, number of code digits (1..8)
SECRET, 16'h0007, BCD secret, 4*DIGITS bits, most significant digit entered first
MAX_FAIL, 3, consecutive wrong codes before lockout (1..15)
LOCKOUT_CYC, 1024, lockout duration in clk cycles (>=2)
TIMEOUT_CYC, 4096, idle cycles before a partial entry is discarded (optional feature only)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
tenkey  input  10  one-hot keypad, bit n = digit n, all-zero = no key
close  input  1  level; request to lock and clear entry
lock  output  1  1 = door locked
err  output  1  one-cycle pulse on wrong code
lockout  output  1  1 while in LOCKOUT
digit_cnt  output  4  digits entered in the current attempt
fail_cnt  output  4  consecutive failures

Behaviour:
- Reset is asynchronous, active-high. Reset values: state LOCKED, lock=1, err=0, lockout=0, digit_cnt=0, fail_cnt=0, entry buffer all 4'hF.
- Key press: tenkey is registered once. A press is a cycle where the registered value is exactly one-hot and the previous registered value was all-zero. Each press yields exactly one digit. Non-one-hot patterns (multi-press) are ignored and do not re-arm the edge detector until tenkey returns to zero.
- States: LOCKED, CHECK, OPEN, LOCKOUT.
- LOCKED:
  - A press shifts the digit into the buffer from the LSB side and increments digit_cnt.
  - When digit_cnt reaches DIGITS, go to CHECK on the next cycle.
  - close=1 clears the buffer and digit_cnt. close has priority over a same-cycle press.
- CHECK (one cycle):
  - If buffer == SECRET: go to OPEN, lock<=0, fail_cnt<=0.
  - Otherwise: err=1 for this cycle, fail_cnt increments (saturating at 15), buffer and digit_cnt clear.
  - After a mismatch, go to LOCKOUT if the new fail_cnt == MAX_FAIL, else return to LOCKED.
  - Total latency from the final press cycle to lock deasserting is 2 cycles.
- OPEN:
  - lock=0 and presses are ignored.
  - close=1 gives lock<=1, buffer clear, digit_cnt<=0, next state LOCKED.
- LOCKOUT:
  - lockout=1, lock=1; presses and close are ignored.
  - A down-counter loads LOCKOUT_CYC-1 on entry. At zero, go to LOCKED with fail_cnt<=0.
- Reset mid-entry or mid-lockout returns immediately to the reset values.
- Width rules:
  - The buffer is 4*DIGITS bits.
  - The lockout counter is $clog2(LOCKOUT_CYC) bits.
  - digit_cnt never exceeds DIGITS.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined:
  - An idle counter runs while in LOCKED with digit_cnt>0. It resets on each press.
  - After TIMEOUT_CYC cycles with no press, the buffer and digit_cnt clear.
  - A timeout does not count as a failure and does not pulse err.
- Undefined: a partial entry persists indefinitely until it completes, close is asserted, or reset.

Decomposition:
- Package elelock_pkg:
  - state enum (LOCKED, CHECK, OPEN, LOCKOUT)
  - KEY_NONE = 4'hF
  - keyenc function, one-hot 10-bit to 4-bit BCD, returning KEY_NONE for non-one-hot input
- Sub-module tenkey_press: input register, one-hot check, zero-rearm edge detect. Outputs press_valid and press_digit[3:0].

Test Plan:
- DIGITS=4, SECRET=16'h1234: press 1,2,3,4 with tenkey returning to zero between presses -> lock falls 2 cycles after the 4th press, fail_cnt=0, err never asserted.
- Press 1,2,3,5 -> single-cycle err, fail_cnt=1, digit_cnt=0, lock=1.
- MAX_FAIL=3, LOCKOUT_CYC=16: three wrong codes -> lockout=1 for exactly 16 cycles and presses are ignored. Then fail_cnt=0 and the correct code opens the lock.
- Hold tenkey=10'b0000000010 for 5 cycles -> digit_cnt increments by 1 only. Apply tenkey=10'b0000000011 -> no digit accepted.
- Enter 1,2, then close=1 in the same cycle as the press of 3 -> digit_cnt=0. A subsequent 1,2,3,4 opens the lock. While OPEN, close=1 -> lock=1 next cycle.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYC=32: press 1 then idle 32 cycles -> digit_cnt=0, err=0, fail_cnt unchanged. Assert reset during LOCKOUT -> immediate return to the reset values.
